// File: rtl/cpstr_mgr_tx.sv
// Device->host channelised byte stream merger.
// Marks stream switches with {ESC,idx} and escapes literal ESC bytes.
module cpstr_mgr_tx #(
  parameter int          NUM_STREAMS = 4,
  parameter logic [7:0]  ESC_CHAR    = 8'h1B,
  parameter int          MAX_BURST   = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [8*NUM_STREAMS-1:0] i_data,
  input  logic [NUM_STREAMS-1:0]   i_valid,
  output logic [NUM_STREAMS-1:0]   o_ready,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     i_send_stridx,
  output logic [3:0]               o_stridx
);
  localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    ARB, SEL_ESC, SEL_IDX, DATA, LIT2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_cur;
  logic [CW-1:0]   r_cnt;
  logic            r_pend;
  logic            r_late;
  logic [7:0]      r_odata;
  logic            r_ovalid;

  state_t                 w_nstate;
  logic [IW-1:0]          w_ncur;
  logic [IW-1:0]          w_rr_k;
  logic [IW-1:0]          w_rr_idx;
  logic                   w_rr_hit;
  logic [NUM_STREAMS-1:0] w_mask;
  logic [NUM_STREAMS-1:0] w_ready;
  logic [7:0]             w_byte;
  logic [7:0]             w_ldata;
  logic                   w_free;
  logic                   w_cur_v;
  logic                   w_others;
  logic                   w_sat;
  logic                   w_load;
  logic                   w_sw;
  logic                   w_idx_done;
  logic                   w_cnt_inc;

  assign w_free   = !r_ovalid || i_ready;
  assign w_mask   = NUM_STREAMS'(1) << r_cur;
  assign w_cur_v  = i_valid[r_cur];
  assign w_others = |(i_valid & ~w_mask);
  assign w_sat    = (r_cnt == CW'(MAX_BURST));
  assign w_byte   = i_data[{r_cur, 3'b000} +: 8];

  // Descending scan so the nearest stream after cur wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = r_cur;
    w_rr_k   = r_cur;
    for (int i = NUM_STREAMS - 1; i >= 1; i--) begin
      w_rr_k = IW'((int'(r_cur) + i) % NUM_STREAMS);
      if (i_valid[w_rr_k]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_rr_k;
      end
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_ncur     = r_cur;
    w_ready    = '0;
    w_load     = 1'b0;
    w_ldata    = r_odata;
    w_sw       = 1'b0;
    w_idx_done = 1'b0;
    w_cnt_inc  = 1'b0;
    unique case (r_state)
      ARB: begin
        if (w_cur_v && !(w_sat && w_others)) begin
          w_nstate = r_pend ? SEL_ESC : DATA;
        end else if (w_rr_hit) begin
          w_ncur   = w_rr_idx;
          w_sw     = 1'b1;
          w_nstate = SEL_ESC;
        end
      end
      SEL_ESC: begin
        if (w_free) begin
          w_load   = 1'b1;
          w_ldata  = ESC_CHAR;
          w_nstate = SEL_IDX;
        end
      end
      SEL_IDX: begin
        if (w_free) begin
          w_load     = 1'b1;
          w_ldata    = 8'(r_cur);
          w_idx_done = 1'b1;
          w_nstate   = DATA;
        end
      end
      DATA: begin
        if (!w_cur_v || (w_sat && w_others)) begin
          w_nstate = ARB;
        end else if (r_pend) begin
          w_nstate = SEL_ESC;
        end else if (w_free) begin
          w_ready   = w_mask;
          w_load    = 1'b1;
          w_ldata   = w_byte;
          w_cnt_inc = 1'b1;
          if (w_byte == ESC_CHAR) w_nstate = LIT2;
        end
      end
      LIT2: begin
        if (w_free) begin
          w_load   = 1'b1;
          w_ldata  = ESC_CHAR;
          w_nstate = DATA;
        end
      end
      default: w_nstate = ARB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ARB;
      r_cur    <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b1;
      r_late   <= 1'b0;
      r_odata  <= 8'h00;
      r_ovalid <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cur   <= w_ncur;
      if (w_idx_done) r_cnt <= '0;
      else if (w_cnt_inc && !w_sat) r_cnt <= r_cnt + CW'(1);
      // A request seen while in SEL_IDX must survive the clear.
      if (r_state == SEL_IDX && !w_idx_done)
        r_late <= r_late || i_send_stridx;
      else
        r_late <= 1'b0;
      if (w_idx_done) r_pend <= r_late || i_send_stridx;
      else r_pend <= r_pend || i_send_stridx || w_sw;
      if (w_load) begin
        r_odata  <= w_ldata;
        r_ovalid <= 1'b1;
      end else if (i_ready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  assign o_ready  = w_ready;
  assign o_data   = r_odata;
  assign o_valid  = r_ovalid;
  assign o_stridx = 4'(r_cur);
endmodule

// File: tb/tb_cpstr_mgr_tx.sv
// Self-checking bench for cpstr_mgr_tx.
// Sources and link expectations live in queues.
module tb_cpstr_mgr_tx;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [8*NS-1:0] i_data;
  logic [NS-1:0] i_valid;
  logic [NS-1:0] o_ready;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          i_ready;
  logic          i_send_stridx;
  logic [3:0]    o_stridx;

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];
  logic [7:0] srcq[NS][$];
  int rc[NS];

  always #5 clk = ~clk;

  cpstr_mgr_tx #(
    .NUM_STREAMS(NS),
    .ESC_CHAR(8'h1B),
    .MAX_BURST(4)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .i_send_stridx(i_send_stridx),
    .o_stridx(o_stridx)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic [7:0] b);
    srcq[k].push_back(b);
  endtask

  task automatic ex(input logic [7:0] b);
    expq.push_back(b);
  endtask

  task automatic clr_rc();
    for (int k = 0; k < NS; k++) rc[k] = 0;
  endtask

  function automatic bit srcs_empty();
    for (int k = 0; k < NS; k++)
      if (srcq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (expq.size() == 0 && srcs_empty()) begin
        done = 1'b1;
        break;
      end
      @(negedge clk); #2;
    end
    chk({"drain_", tag}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    #2;
  endtask

  // Link monitor: a byte moves when o_valid && i_ready at the edge.
  always @(negedge clk) begin
    if (!i_rst) begin
      for (int k = 0; k < NS; k++) rc[k] += int'(o_ready[k]);
      chk("ready_onehot", 32'($onehot0(o_ready)), 32'd1);
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL link_extra got %0h want none", o_data);
        end else begin
          chk("link", 32'(o_data), 32'(expq.pop_front()));
        end
      end
    end
  end

  // Stream sources driven from their queues.
  initial begin
    logic [NS-1:0] take;
    i_valid = '0;
    i_data  = '0;
    forever begin
      @(negedge clk);
      take = o_ready & i_valid;
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) begin
        if (take[k]) void'(srcq[k].pop_front());
        i_valid[k] = (srcq[k].size() != 0);
        i_data[8*k +: 8] = i_valid[k] ? srcq[k][0] : 8'h00;
      end
    end
  end

  initial begin
    bit found;
    i_rst = 1'b1;
    i_ready = 1'b1;
    i_send_stridx = 1'b0;
    clr_rc();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_stridx", 32'(o_stridx), 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk); #2;

    // Stream 0 after reset: announced then two bytes.
    clr_rc();
    put(0, 8'h41); put(0, 8'h42);
    ex(8'h1B); ex(8'h00); ex(8'h41); ex(8'h42);
    drain("t1");
    chk("t1_ready0", 32'(rc[0]), 32'd2);

    // Literal escape on stream 2.
    clr_rc();
    put(2, 8'h1B); put(2, 8'h55);
    ex(8'h1B); ex(8'h02); ex(8'h1B); ex(8'h1B); ex(8'h55);
    drain("t2");
    chk("t2_ready2", 32'(rc[2]), 32'd2);
    chk("t2_stridx", 32'(o_stridx), 32'd2);

    // Burst limit alternation; search starts after stream 2.
    clr_rc();
    for (int i = 0; i < 10; i++) begin
      put(1, 8'(8'h10 + i));
      put(3, 8'(8'h30 + i));
    end
    for (int b = 0; b < 3; b++) begin
      int n;
      n = (b == 2) ? 2 : 4;
      ex(8'h1B); ex(8'h03);
      for (int i = 0; i < n; i++) ex(8'(8'h30 + 4 * b + i));
      ex(8'h1B); ex(8'h01);
      for (int i = 0; i < n; i++) ex(8'(8'h10 + 4 * b + i));
    end
    drain("t3");
    chk("t3_ready1", 32'(rc[1]), 32'd10);
    chk("t3_ready3", 32'(rc[3]), 32'd10);
    chk("t3_stridx", 32'(o_stridx), 32'd1);

    // Two index requests coalesce into one announcement.
    for (int i = 0; i < 6; i++) put(0, 8'(8'h60 + i));
    ex(8'h1B); ex(8'h00);
    ex(8'h60); ex(8'h61); ex(8'h62);
    ex(8'h1B); ex(8'h00);
    ex(8'h63); ex(8'h64); ex(8'h65);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_valid && o_data == 8'h61) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_seen61", 32'(found), 32'd1);
    #1 i_send_stridx = 1'b1;
    @(posedge clk); #1 i_send_stridx = 1'b0;
    @(posedge clk); #1 i_send_stridx = 1'b1;
    @(posedge clk); #1 i_send_stridx = 1'b0;
    drain("t4");

    // Link stall holds the slot and blocks inputs.
    for (int i = 0; i < 4; i++) put(2, 8'(8'h80 + i));
    ex(8'h1B); ex(8'h02);
    for (int i = 0; i < 4; i++) ex(8'(8'h80 + i));
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_valid && o_data == 8'h80) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_seen80", 32'(found), 32'd1);
    @(posedge clk); #1 i_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(o_valid), 32'd1);
      chk("t5_hold_data", 32'(o_data), 32'h81);
      chk("t5_hold_ready", 32'(o_ready), 32'd0);
    end
    @(posedge clk); #1 i_ready = 1'b1;
    drain("t5");

    // Reset between the two bytes of a literal pair.
    put(2, 8'h70); put(2, 8'h1B); put(2, 8'h55);
    ex(8'h70); ex(8'h1B);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      if (expq.size() == 0) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_pair_start", 32'(found), 32'd1);
    i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_drop", 32'(o_valid), 32'd0);
    chk("t6_stridx_rst", 32'(o_stridx), 32'd0);
    ex(8'h1B); ex(8'h02); ex(8'h55);
    drain("t6");
    chk("t6_stridx", 32'(o_stridx), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
